// File: rtl/l2_arbiter.sv
// Round-robin arbiter that shares the single L2 port between the L1 I-cache and D-cache miss paths.
// Optional performance counters are compiled in when L2ARB_PERF_EN is defined.
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
`ifdef L2ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_i_grants,
    output logic [CNT_W-1:0]  perf_d_grants,
    output logic [CNT_W-1:0]  perf_contention
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;  // 0: I-cache, 1: D-cache
    logic                l2_read_q, l2_read_d;
    logic                l2_write_q, l2_write_d;
    logic [ADDR_W-1:0]   l2_address_q, l2_address_d;
    logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;

    logic dreq;
    logic grant_i;
    logic grant_d;

    // Under contention the side that was not served last wins.
    assign dreq    = dcache_read | dcache_write;
    assign grant_i = (state_q == IDLE) && icache_read && (!dreq || last_grant_q);
    assign grant_d = (state_q == IDLE) && dreq && (!icache_read || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        l2_address_d = l2_address_q;
        l2_wdata_d   = l2_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = SERVE_D;
                    l2_address_d = dcache_address;
                    l2_wdata_d   = dcache_wdata;
                    // A simultaneous read+write from the D-cache is treated as a writeback.
                    l2_write_d   = dcache_write;
                    l2_read_d    = ~dcache_write;
                end else if (grant_i) begin
                    state_d      = SERVE_I;
                    l2_address_d = icache_address;
                    l2_read_d    = 1'b1;
                    l2_write_d   = 1'b0;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                    l2_read_d    = 1'b0;
                    l2_write_d   = 1'b0;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                    l2_read_d    = 1'b0;
                    l2_write_d   = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            l2_address_q <= l2_address_d;
            l2_wdata_q   <= l2_wdata_d;
        end
    end

    assign l2_read      = l2_read_q;
    assign l2_write     = l2_write_q;
    assign l2_address   = l2_address_q;
    assign l2_wdata     = l2_wdata_q;
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;
    assign icache_resp  = (state_q == SERVE_I) && l2_resp;
    assign dcache_resp  = (state_q == SERVE_D) && l2_resp;

`ifdef L2ARB_PERF_EN
    logic [CNT_W-1:0] perf_i_q, perf_i_d;
    logic [CNT_W-1:0] perf_d_q, perf_d_d;
    logic [CNT_W-1:0] perf_c_q, perf_c_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        perf_i_d = perf_i_q;
        perf_d_d = perf_d_q;
        perf_c_d = perf_c_q;
        if (grant_i) perf_i_d = sat_inc(perf_i_q);
        if (grant_d) perf_d_d = sat_inc(perf_d_q);
        if ((state_q == IDLE) && icache_read && dreq) perf_c_d = sat_inc(perf_c_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_i_grants   = perf_i_q;
    assign perf_d_grants   = perf_d_q;
    assign perf_contention = perf_c_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_l2_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              icache_read = 1'b0;
    logic [ADDR_W-1:0] icache_address = '0;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read = 1'b0;
    logic              dcache_write = 1'b0;
    logic [ADDR_W-1:0] dcache_address = '0;
    logic [LINE_W-1:0] dcache_wdata = '0;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata = '0;
    logic              l2_resp = 1'b0;
`ifdef L2ARB_PERF_EN
    logic [CNT_W-1:0]  perf_i_grants;
    logic [CNT_W-1:0]  perf_d_grants;
    logic [CNT_W-1:0]  perf_contention;
`endif

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
`ifdef L2ARB_PERF_EN
        , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_contention(perf_contention)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: which side owns the L2 port and the command it latched.
    int                m_side = 0;      // 0 none, 1 I-cache, 2 D-cache
    bit                m_last_d = 1'b0;
    bit                m_rd = 1'b0;
    bit                m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    logic [CNT_W-1:0]  m_pi = '0, m_pd = '0, m_pc = '0;
    bit                m_iq, m_dq;

    function automatic logic [CNT_W-1:0] sat1(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_side = 0; m_last_d = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
            m_pi = '0; m_pd = '0; m_pc = '0;
        end else if (m_side == 0) begin
            m_iq = icache_read;
            m_dq = dcache_read | dcache_write;
            if (m_iq && m_dq) m_pc = sat1(m_pc);
            if (m_dq && (!m_iq || !m_last_d)) begin
                m_side = 2; m_addr = dcache_address; m_wdata = dcache_wdata;
                m_wr = dcache_write; m_rd = !dcache_write; m_pd = sat1(m_pd);
            end else if (m_iq) begin
                m_side = 1; m_addr = icache_address; m_rd = 1; m_wr = 0; m_pi = sat1(m_pi);
            end
        end else if (l2_resp) begin
            m_last_d = (m_side == 2);
            m_side = 0; m_rd = 0; m_wr = 0;
        end
    end

    always @(negedge clk) begin
        chk("l2_read", l2_read, m_rd);
        chk("l2_write", l2_write, m_wr);
        chk("l2_address", l2_address, m_addr);
        if (m_wr) chk("l2_wdata", l2_wdata, m_wdata);
        chk("icache_resp", icache_resp, reset_n && (m_side == 1) && l2_resp);
        chk("dcache_resp", dcache_resp, reset_n && (m_side == 2) && l2_resp);
        chk("icache_rdata", icache_rdata, l2_rdata);
        chk("dcache_rdata", dcache_rdata, l2_rdata);
`ifdef L2ARB_PERF_EN
        chk("perf_i", perf_i_grants, m_pi);
        chk("perf_d", perf_d_grants, m_pd);
        chk("perf_c", perf_contention, m_pc);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_read = 0; dcache_read = 0; dcache_write = 0; l2_resp = 0;
    endtask

    initial begin
        logic [LINE_W-1:0] a5;
        logic [LINE_W-1:0] p55;
        a5  = {16{8'hA5}};
        p55 = {16{8'h55}};

        tick(); tick();
        chk("rst l2_read", l2_read, 0);
        chk("rst l2_write", l2_write, 0);
        chk("rst l2_address", l2_address, 0);
        chk("rst l2_wdata", l2_wdata, 0);
        chk("rst icache_resp", icache_resp, 0);
        chk("rst dcache_resp", dcache_resp, 0);
        reset_n = 1;

        // I-cache fill
        tick();
        icache_read = 1; icache_address = 16'h1230;
        tick();
        chk("i l2_read", l2_read, 1);
        chk("i l2_address", l2_address, 16'h1230);
        l2_rdata = a5; l2_resp = 1; #1;
        chk("i resp", icache_resp, 1);
        chk("i rdata", icache_rdata, a5);
        chk("i no dresp", dcache_resp, 0);
        tick();
        clear_inputs();
        chk("i dead cycle", l2_read, 0);
        tick();

        // D-cache writeback held over several wait cycles
        dcache_write = 1; dcache_address = 16'h4000; dcache_wdata = p55;
        tick();
        for (int k = 0; k < 5; k++) begin
            dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
            chk("d l2_write", l2_write, 1);
            chk("d l2_wdata held", l2_wdata, p55);
            chk("d l2_address", l2_address, 16'h4000);
            tick();
        end
        l2_resp = 1; #1;
        chk("d resp", dcache_resp, 1);
        chk("d no iresp", icache_resp, 0);
        tick();
        clear_inputs();
        tick();

        // Contention after reset alternates D, I, D
        reset_n = 0; tick(); reset_n = 1;
        icache_read = 1; icache_address = 16'h1111;
        dcache_read = 1; dcache_address = 16'h2222;
        tick();
        chk("c1 D first", l2_address, 16'h2222);
        chk("c1 read", l2_read, 1);
        tick(); l2_resp = 1; tick(); l2_resp = 0;
        chk("c dead read", l2_read, 0);
        chk("c dead write", l2_write, 0);
        tick();
        chk("c2 I next", l2_address, 16'h1111);
        l2_resp = 1; tick(); l2_resp = 0; tick();
        chk("c3 D again", l2_address, 16'h2222);
        l2_resp = 1; tick(); clear_inputs(); tick();

        // Illegal read+write resolves to write
        dcache_read = 1; dcache_write = 1; dcache_address = 16'h3000;
        tick();
        chk("rw l2_write", l2_write, 1);
        chk("rw l2_read", l2_read, 0);
        l2_resp = 1; tick(); clear_inputs(); tick();

        // Asynchronous reset during SERVE_I
        icache_read = 1; icache_address = 16'h0AA0;
        tick();
        chk("ar serve", l2_read, 1);
        dcache_read = 1; dcache_address = 16'h0BB0;
        #2 reset_n = 0; #1;
        chk("ar l2_read async", l2_read, 0);
        tick(); #1 reset_n = 1;
        tick();
        chk("ar tie grants D", l2_address, 16'h0BB0);
        l2_resp = 1; tick(); clear_inputs(); tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            icache_read    = ($urandom_range(0, 3) != 0);
            icache_address = 16'($urandom);
            dcache_read    = ($urandom_range(0, 2) == 0);
            dcache_write   = ($urandom_range(0, 3) == 0);
            dcache_address = 16'($urandom);
            dcache_wdata   = {$urandom, $urandom, $urandom, $urandom};
            l2_rdata       = {$urandom, $urandom, $urandom, $urandom};
            l2_resp        = ($urandom_range(0, 2) == 0);
            reset_n        = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1;
        clear_inputs();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
